acq_session_ctrl: RTL and testbench
===================================

ACQ_SESSION_CTRL -- requirements
Module: acq_session_ctrl

Interface
REQ-001 Parameter RHD_BASE, default 32'h0000_0000, AXI4-Lite base address of the RHD acquisition core.
REQ-002 Parameter RHS_BASE, default 32'h0001_0000, AXI4-Lite base address of the RHS stimulation core.
REQ-003 Parameter CNT_W, default 32, width of the wait counters.
REQ-004 aclk  in  1  single clock for all logic.
REQ-005 areset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; begins a session from IDLE and is ignored elsewhere.
REQ-007 abort  in  1  level; forces an orderly stop.
REQ-008 cfg_rhd_delay, cfg_rhd_pkt_len, cfg_rhd_run, cfg_rhs_run  in  32 each  register values written during the session.
REQ-009 cfg_pre_cycles, cfg_run_cycles  in  CNT_W each  delay from stim enable to acquisition start, and acquisition duration.
REQ-010 m_awaddr/m_awvalid/m_awready, m_wdata/m_wstrb/m_wvalid/m_wready, m_bresp/m_bvalid/m_bready  AXI4-Lite master write channels (32-bit address and data).
REQ-011 m_araddr/m_arvalid/m_arready, m_rdata/m_rresp/m_rvalid/m_rready  AXI4-Lite master read channels.
REQ-012 busy, done, err  out  1 each; state  out  4  current FSM state code.

Function
REQ-013 The FSM SHALL step through IDLE, W_DLY (RHD+0x4 <= cfg_rhd_delay), W_PKT (RHD+0x8 <= cfg_rhd_pkt_len), W_STIM (RHS+0x0 <= cfg_rhs_run), PRE_WAIT, W_ACQ (RHD+0x0 <= cfg_rhd_run), RUN_WAIT, W_RHS_STOP (RHS+0x0 <= 0), W_RHD_STOP (RHD+0x0 <= 0), DONE.
REQ-014 Config inputs SHALL be sampled into holding registers on the accepted start pulse; later changes SHALL NOT affect the running session.
REQ-015 Each W_* state SHALL issue exactly one write with wstrb=4'hF, assert awvalid and wvalid together, drop each independently on its own ready, and assert bready until bvalid.
REQ-016 A W_* state SHALL advance on the cycle after the B handshake; back-to-back writes SHALL NOT overlap.
REQ-017 PRE_WAIT SHALL last exactly cfg_pre_cycles cycles, and RUN_WAIT exactly cfg_run_cycles cycles; a value of 0 SHALL advance after one cycle.
REQ-018 A bresp other than OKAY SHALL set err sticky until the next start, then jump to W_RHS_STOP, or to DONE if the failing write was itself a stop write.
REQ-019 abort SHALL be honoured after any in-flight write completes: before W_STIM it goes to DONE; from W_STIM through RUN_WAIT it goes to W_RHS_STOP.
REQ-020 Both stop writes SHALL always be issued once W_STIM has completed, even under abort or err.
REQ-021 busy SHALL be 1 in every state except IDLE and DONE; done SHALL pulse for one cycle on DONE, then the FSM returns to IDLE.
REQ-022 start arriving together with abort SHALL be ignored.

Reset
REQ-023 areset SHALL asynchronously force IDLE, with all valid/ready outputs 0, busy=0, done=0, err=0, state=0, and counters cleared.
REQ-024 Reset mid-transaction SHALL drop all valids immediately; no stop writes are issued.

Configuration
REQ-025 With SESSION_READBACK_EN defined, each write SHALL be followed by a read of the same address; rdata differing from the written value, or a non-OKAY rresp, SHALL set err and be handled as in REQ-018.
REQ-026 Without SESSION_READBACK_EN, m_arvalid and m_rready SHALL be tied 0 and the read ports SHALL be unused.

Structure
REQ-027 Package acq_session_pkg SHALL hold the state enum, the register offsets (CTRL=0x0, DELAY=0x4, PKTLEN=0x8), and the AXI response codes.
REQ-028 The single-write (and optional read-back) handshake engine SHALL be a sub-module named axil_single_master, with start/addr/data in and done/err out.

Verification
REQ-029 Start with delay=0x22222222, pkt=2, rhs_run=0x29, rhd_run=0x15, pre=10, run=100, always-ready slave -> writes in order 0x4, 0x8, RHS+0x0, RHD+0x0, RHS+0x0=0, RHD+0x0=0; the RHD start write lands 10 cycles after the STIM B handshake; done pulses once; err=0.
REQ-030 Slave with awready delayed 3 cycles and wready immediate -> each channel drops valid independently; data is correct; no duplicate writes.
REQ-031 SLVERR on the W_PKT write -> err=1; only the two stop writes follow; done pulses.
REQ-032 abort asserted during RUN_WAIT at cycle 50 -> both stop writes are issued; done pulses; err=0.
REQ-033 areset asserted while awvalid=1 in W_ACQ -> outputs return to their reset values asynchronously; a later start runs a full session.
REQ-034 With SESSION_READBACK_EN defined, the slave returns rdata=0x0 for the 0x8 read -> err=1 and the stop sequence runs.

Source files
------------

// File: rtl/acq_session_pkg.sv
// acq_session_pkg: session FSM state codes, register offsets and AXI response codes
package acq_session_pkg;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_W_DLY      = 4'd1,
        S_W_PKT      = 4'd2,
        S_W_STIM     = 4'd3,
        S_PRE_WAIT   = 4'd4,
        S_W_ACQ      = 4'd5,
        S_RUN_WAIT   = 4'd6,
        S_W_RHS_STOP = 4'd7,
        S_W_RHD_STOP = 4'd8,
        S_DONE       = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    localparam logic [31:0] REG_CTRL   = 32'h0;
    localparam logic [31:0] REG_DELAY  = 32'h4;
    localparam logic [31:0] REG_PKTLEN = 32'h8;

    function automatic logic is_write_state(state_t s);
        return s inside {S_W_DLY, S_W_PKT, S_W_STIM, S_W_ACQ, S_W_RHS_STOP, S_W_RHD_STOP};
    endfunction

endpackage

// File: rtl/axil_single_master.sv
// axil_single_master: one AXI4-Lite write per start pulse; read-back of the same address when SESSION_READBACK_EN is defined
module axil_single_master
    import acq_session_pkg::*;
(
    input  logic        aclk,
    input  logic        areset,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic        done,
    output logic        err,
    output logic [31:0] m_awaddr,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready
);

    logic [31:0] addr_q, addr_d, data_q, data_d;
    logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic        b_hs, b_ok;

    // Address and data channels rise together on start and fall independently on their own ready
    always_comb begin
        addr_d    = start ? addr : addr_q;
        data_d    = start ? data : data_q;
        awvalid_d = start || (awvalid_q && !m_awready);
        wvalid_d  = start || (wvalid_q && !m_wready);
        bready_d  = start || (bready_q && !m_bvalid);
        b_hs      = bready_q && m_bvalid;
        b_ok      = m_bresp == RESP_OKAY;
    end

    // Write channel registers
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            addr_q    <= '0;
            data_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            data_q    <= data_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
        end
    end

    assign m_awaddr  = addr_q;
    assign m_awvalid = awvalid_q;
    assign m_wdata   = data_q;
    assign m_wstrb   = 4'hF;
    assign m_wvalid  = wvalid_q;
    assign m_bready  = bready_q;
    assign m_araddr  = addr_q;

`ifdef SESSION_READBACK_EN
    logic arvalid_q, arvalid_d, rready_q, rready_d, r_hs;

    // A clean write response launches the read-back; a mismatch or bad rresp flags the transaction
    always_comb begin
        arvalid_d = (b_hs && b_ok) || (arvalid_q && !m_arready);
        rready_d  = (b_hs && b_ok) || (rready_q && !m_rvalid);
        r_hs      = rready_q && m_rvalid;
        done      = (b_hs && !b_ok) || r_hs;
        err       = (b_hs && !b_ok) || (r_hs && (m_rresp != RESP_OKAY || m_rdata != data_q));
    end

    // Read channel registers
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
        end
    end

    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;
`else
    logic unused_rd;
    assign unused_rd = ^{m_arready, m_rdata, m_rresp, m_rvalid};

    // Write-only: the B handshake ends the transaction
    always_comb begin
        done = b_hs;
        err  = b_hs && !b_ok;
    end

    assign m_arvalid = 1'b0;
    assign m_rready  = 1'b0;
`endif

endmodule

// File: rtl/acq_session_ctrl.sv
// acq_session_ctrl: sequences RHD/RHS register writes for one acquisition session (read-back via SESSION_READBACK_EN)
module acq_session_ctrl
    import acq_session_pkg::*;
#(
    parameter logic [31:0] RHD_BASE = 32'h0000_0000,
    parameter logic [31:0] RHS_BASE = 32'h0001_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      cfg_rhd_delay,
    input  logic [31:0]      cfg_rhd_pkt_len,
    input  logic [31:0]      cfg_rhd_run,
    input  logic [31:0]      cfg_rhs_run,
    input  logic [CNT_W-1:0] cfg_pre_cycles,
    input  logic [CNT_W-1:0] cfg_run_cycles,
    output logic [31:0]      m_awaddr,
    output logic             m_awvalid,
    input  logic             m_awready,
    output logic [31:0]      m_wdata,
    output logic [3:0]       m_wstrb,
    output logic             m_wvalid,
    input  logic             m_wready,
    input  logic [1:0]       m_bresp,
    input  logic             m_bvalid,
    output logic             m_bready,
    output logic [31:0]      m_araddr,
    output logic             m_arvalid,
    input  logic             m_arready,
    input  logic [31:0]      m_rdata,
    input  logic [1:0]       m_rresp,
    input  logic             m_rvalid,
    output logic             m_rready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [3:0]       state
);

    state_t           state_q, state_d;
    logic             go_q, go_d, err_q, err_d, start_ok;
    logic [CNT_W-1:0] cnt_q, cnt_d, lim, pre_q, pre_d, run_q, run_d;
    logic [31:0]      dly_q, dly_d, pkt_q, pkt_d, rhd_run_q, rhd_run_d, rhs_run_q, rhs_run_d;
    logic [31:0]      wr_addr, wr_data;
    logic             eng_done, eng_err, wait_last;

    axil_single_master u_axil (
        .aclk      (aclk),
        .areset    (areset),
        .start     (go_q),
        .addr      (wr_addr),
        .data      (wr_data),
        .done      (eng_done),
        .err       (eng_err),
        .m_awaddr  (m_awaddr),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_bresp   (m_bresp),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready),
        .m_araddr  (m_araddr),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready)
    );

    // State register plus session holding registers, wait counter and sticky error
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= S_IDLE;
            go_q      <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            pre_q     <= '0;
            run_q     <= '0;
            dly_q     <= '0;
            pkt_q     <= '0;
            rhd_run_q <= '0;
            rhs_run_q <= '0;
        end else begin
            state_q   <= state_d;
            go_q      <= go_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            pre_q     <= pre_d;
            run_q     <= run_d;
            dly_q     <= dly_d;
            pkt_q     <= pkt_d;
            rhd_run_q <= rhd_run_d;
            rhs_run_q <= rhs_run_d;
        end
    end

    // Next state: writes advance only after their transaction ends, so abort waits for in-flight writes
    always_comb begin
        lim       = (state_q == S_PRE_WAIT) ? pre_q : run_q;
        wait_last = (lim == '0) || (cnt_q == lim - 1'b1);
        start_ok  = (state_q == S_IDLE) && start && !abort;
        state_d   = state_q;
        case (state_q)
            S_IDLE:       state_d = start_ok ? S_W_DLY : S_IDLE;
            S_W_DLY,
            S_W_PKT:      if (eng_done) state_d = eng_err ? S_W_RHS_STOP : abort ? S_DONE :
                                                  (state_q == S_W_DLY) ? S_W_PKT : S_W_STIM;
            S_W_STIM:     if (eng_done) state_d = (eng_err || abort) ? S_W_RHS_STOP : S_PRE_WAIT;
            S_PRE_WAIT:   state_d = abort ? S_W_RHS_STOP : wait_last ? S_W_ACQ : S_PRE_WAIT;
            S_W_ACQ:      if (eng_done) state_d = (eng_err || abort) ? S_W_RHS_STOP : S_RUN_WAIT;
            S_RUN_WAIT:   state_d = (abort || wait_last) ? S_W_RHS_STOP : S_RUN_WAIT;
            S_W_RHS_STOP: if (eng_done) state_d = eng_err ? S_DONE : S_W_RHD_STOP;
            S_W_RHD_STOP: if (eng_done) state_d = S_DONE;
            S_DONE:       state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
        go_d      = is_write_state(state_d) && (state_d != state_q);
        cnt_d     = ((state_q == S_PRE_WAIT || state_q == S_RUN_WAIT) && state_d == state_q) ? cnt_q + 1'b1 : '0;
        err_d     = start_ok ? 1'b0 : (err_q || (eng_done && eng_err));
        pre_d     = start_ok ? cfg_pre_cycles  : pre_q;
        run_d     = start_ok ? cfg_run_cycles  : run_q;
        dly_d     = start_ok ? cfg_rhd_delay   : dly_q;
        pkt_d     = start_ok ? cfg_rhd_pkt_len : pkt_q;
        rhd_run_d = start_ok ? cfg_rhd_run     : rhd_run_q;
        rhs_run_d = start_ok ? cfg_rhs_run     : rhs_run_q;
    end

    // Outputs: register target per write state and session status
    always_comb begin
        wr_addr = RHD_BASE + REG_CTRL;
        wr_data = '0;
        case (state_q)
            S_W_DLY:      begin wr_addr = RHD_BASE + REG_DELAY;  wr_data = dly_q;     end
            S_W_PKT:      begin wr_addr = RHD_BASE + REG_PKTLEN; wr_data = pkt_q;     end
            S_W_STIM:     begin wr_addr = RHS_BASE + REG_CTRL;   wr_data = rhs_run_q; end
            S_W_ACQ:      begin wr_addr = RHD_BASE + REG_CTRL;   wr_data = rhd_run_q; end
            S_W_RHS_STOP: wr_addr = RHS_BASE + REG_CTRL;
            default:      wr_addr = RHD_BASE + REG_CTRL;
        endcase
        busy  = (state_q != S_IDLE) && (state_q != S_DONE);
        done  = state_q == S_DONE;
        err   = err_q;
        state = state_q;
    end

endmodule

// File: tb/tb_acq_session_ctrl.sv
// tb_acq_session_ctrl: directed session scenarios against a behavioural AXI4-Lite slave
module tb_acq_session_ctrl;

    localparam logic [31:0] RHS = 32'h0001_0000;

    logic        aclk = 1'b0;
    logic        areset, start, abort;
    logic [31:0] cfg_rhd_delay, cfg_rhd_pkt_len, cfg_rhd_run, cfg_rhs_run, cfg_pre_cycles, cfg_run_cycles;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [3:0]  m_wstrb, state;
    logic [1:0]  m_bresp, m_rresp;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready, busy, done, err;

    int total = 0, bad = 0;
    int nwr, err_idx, aw_dly, aw_wait;
    int pre_cnt, run_cnt, done_cnt, split_cnt, ar_cnt, strb_bad;
    logic [31:0] log_a [16], log_d [16];
    logic [31:0] aw_addr, w_data, ar_addr, last_wdata;
    logic got_aw, got_w, aw_fire, w_fire, b_fire, ar_fire, r_fire, bad_rd;

    acq_session_ctrl #(.RHD_BASE(32'h0), .RHS_BASE(RHS), .CNT_W(32)) dut (
        .aclk(aclk), .areset(areset), .start(start), .abort(abort),
        .cfg_rhd_delay(cfg_rhd_delay), .cfg_rhd_pkt_len(cfg_rhd_pkt_len),
        .cfg_rhd_run(cfg_rhd_run), .cfg_rhs_run(cfg_rhs_run),
        .cfg_pre_cycles(cfg_pre_cycles), .cfg_run_cycles(cfg_run_cycles),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .busy(busy), .done(done), .err(err), .state(state)
    );

    always #5 aclk = ~aclk;

    // Slave: decides readies at the falling edge; handshakes complete on the following rising edge
    always @(negedge aclk) begin
        if (areset) begin
            m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
            m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
            got_aw = 0; got_w = 0; aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0; aw_wait = 0;
        end else begin
            if (aw_fire) got_aw = 1;
            if (w_fire) got_w = 1;
            if (b_fire) m_bvalid = 0;
            if (r_fire) m_rvalid = 0;
            if (ar_fire) begin
                m_rvalid = 1; m_rresp = 0;
                m_rdata = (bad_rd && ar_addr == 32'h8) ? 32'h0 : last_wdata;
            end
            if (got_aw && got_w && !m_bvalid) begin
                if (nwr < 16) begin log_a[nwr] = aw_addr; log_d[nwr] = w_data; end
                m_bresp = (nwr == err_idx) ? 2'b10 : 2'b00;
                last_wdata = w_data; nwr++; got_aw = 0; got_w = 0; m_bvalid = 1;
            end
            aw_wait = (m_awvalid && !got_aw) ? aw_wait + 1 : 0;
            m_awready = m_awvalid && !got_aw && aw_wait > aw_dly;
            m_wready = m_wvalid && !got_w;
            m_arready = m_arvalid && !m_rvalid;
            aw_fire = m_awvalid && m_awready; if (aw_fire) aw_addr = m_awaddr;
            w_fire = m_wvalid && m_wready; if (w_fire) w_data = m_wdata;
            if (w_fire && m_wstrb != 4'hF) strb_bad++;
            b_fire = m_bvalid && m_bready;
            ar_fire = m_arvalid && m_arready; if (ar_fire) ar_addr = m_araddr;
            r_fire = m_rvalid && m_rready;
        end
    end

    always @(negedge aclk) begin
        if (state == 4'd4) pre_cnt++;
        if (state == 4'd6) run_cnt++;
        if (done) done_cnt++;
        if (m_awvalid && !m_wvalid) split_cnt++;
        if (m_arvalid) ar_cnt++;
    end

    task automatic clear_mon();
        nwr = 0; pre_cnt = 0; run_cnt = 0; done_cnt = 0; split_cnt = 0; strb_bad = 0;
        err_idx = -1; aw_dly = 0; bad_rd = 0;
    endtask

    task automatic set_cfg(input logic [31:0] pre, input logic [31:0] run);
        cfg_rhd_delay = 32'h2222_2222; cfg_rhd_pkt_len = 32'h2;
        cfg_rhs_run = 32'h29; cfg_rhd_run = 32'h15;
        cfg_pre_cycles = pre; cfg_run_cycles = run;
    endtask

    task automatic do_start();
        @(negedge aclk); start = 1;
        @(negedge aclk); start = 0;
        cfg_rhd_delay = 32'hDEAD_BEEF; cfg_rhd_pkt_len = 32'h77; cfg_rhs_run = 32'h1;
        cfg_rhd_run = 32'h3; cfg_pre_cycles = 3; cfg_run_cycles = 7;
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge aclk);
            if (done) ok = 1;
        end
        repeat (3) @(negedge aclk);
    endtask

    task automatic test_reset();
        areset = 1;
        repeat (3) @(negedge aclk);
        total++; if (state !== 4'd0) begin bad++; $display("FAIL reset_state got=%0h want=0", state); end
        total++; if ({busy, done, err} !== 3'b000) begin bad++; $display("FAIL reset_status got=%b want=000", {busy, done, err}); end
        total++; if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 5'b0) begin bad++;
            $display("FAIL reset_valids got=%b want=00000", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}); end
        areset = 0;
        repeat (2) @(negedge aclk);
    endtask

    task automatic test_nominal();
        logic [31:0] ea [6], ed [6];
        bit ok;
        ea = '{32'h4, 32'h8, RHS, 32'h0, RHS, 32'h0};
        ed = '{32'h2222_2222, 32'h2, 32'h29, 32'h15, 32'h0, 32'h0};
        clear_mon(); set_cfg(10, 100);
        do_start();
        total++; if ({busy, state} !== {1'b1, 4'd1}) begin bad++; $display("FAIL nom_busy got=%0h want=11", {busy, state}); end
        wait_done(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL nom_timeout got=%0d want=1", ok); end
        total++; if (nwr !== 6) begin bad++; $display("FAIL nom_count got=%0d want=6", nwr); end
        for (int i = 0; i < 6; i++) begin
            total++; if ({log_a[i], log_d[i]} !== {ea[i], ed[i]}) begin bad++;
                $display("FAIL nom_write%0d got=%h/%h want=%h/%h", i, log_a[i], log_d[i], ea[i], ed[i]); end
        end
        total++; if (pre_cnt !== 10) begin bad++; $display("FAIL nom_pre got=%0d want=10", pre_cnt); end
        total++; if (run_cnt !== 100) begin bad++; $display("FAIL nom_run got=%0d want=100", run_cnt); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL nom_done got=%0d want=1", done_cnt); end
        total++; if ({err, busy, state} !== 6'b0) begin bad++; $display("FAIL nom_end got=%b want=0", {err, busy, state}); end
        total++; if (strb_bad !== 0) begin bad++; $display("FAIL nom_wstrb got=%0d want=0", strb_bad); end
    endtask

    task automatic test_zero_wait();
        bit ok;
        clear_mon(); set_cfg(0, 0);
        do_start(); wait_done(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL zero_timeout got=%0d want=1", ok); end
        total++; if ({pre_cnt, run_cnt} !== {32'd1, 32'd1}) begin bad++; $display("FAIL zero_waits got=%0d/%0d want=1/1", pre_cnt, run_cnt); end
        total++; if (nwr !== 6) begin bad++; $display("FAIL zero_count got=%0d want=6", nwr); end
    endtask

    task automatic test_aw_delay();
        bit ok;
        clear_mon(); set_cfg(2, 3); aw_dly = 3;
        do_start(); wait_done(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL awd_timeout got=%0d want=1", ok); end
        total++; if (nwr !== 6) begin bad++; $display("FAIL awd_count got=%0d want=6", nwr); end
        total++; if (split_cnt < 18) begin bad++; $display("FAIL awd_split got=%0d want>=18", split_cnt); end
        total++; if ({log_a[1], log_d[1]} !== {32'h8, 32'h2}) begin bad++; $display("FAIL awd_pkt got=%h/%h want=8/2", log_a[1], log_d[1]); end
        total++; if ({log_a[3], log_d[3]} !== {32'h0, 32'h15}) begin bad++; $display("FAIL awd_acq got=%h/%h want=0/15", log_a[3], log_d[3]); end
    endtask

    task automatic test_slverr();
        bit ok;
        clear_mon(); set_cfg(4, 4); err_idx = 1;
        do_start(); wait_done(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL slv_timeout got=%0d want=1", ok); end
        total++; if (nwr !== 4) begin bad++; $display("FAIL slv_count got=%0d want=4", nwr); end
        total++; if ({log_a[2], log_d[2], log_a[3], log_d[3]} !== {RHS, 32'h0, 32'h0, 32'h0}) begin bad++;
            $display("FAIL slv_stops got=%h/%h %h/%h want=10000/0 0/0", log_a[2], log_d[2], log_a[3], log_d[3]); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL slv_done got=%0d want=1", done_cnt); end
        repeat (5) @(negedge aclk);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL slv_err_sticky got=%b want=1", err); end
    endtask

    task automatic test_abort_run();
        bit ok, seen;
        clear_mon(); set_cfg(10, 100);
        do_start();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL abr_err_clear got=%b want=0", err); end
        seen = 0;
        for (int i = 0; i < 500 && !seen; i++) begin @(negedge aclk); seen = state == 4'd6; end
        repeat (50) @(negedge aclk);
        total++; if (state !== 4'd6) begin bad++; $display("FAIL abr_in_run got=%0h want=6", state); end
        abort = 1;
        wait_done(ok);
        abort = 0;
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL abr_timeout got=%0d want=1", ok); end
        total++; if (nwr !== 6) begin bad++; $display("FAIL abr_count got=%0d want=6", nwr); end
        total++; if ({log_a[4], log_d[4], log_a[5], log_d[5]} !== {RHS, 32'h0, 32'h0, 32'h0}) begin bad++;
            $display("FAIL abr_stops got=%h/%h %h/%h want=10000/0 0/0", log_a[4], log_d[4], log_a[5], log_d[5]); end
        total++; if (run_cnt >= 100) begin bad++; $display("FAIL abr_run_cut got=%0d want<100", run_cnt); end
        total++; if ({err, done_cnt} !== {1'b0, 32'd1}) begin bad++; $display("FAIL abr_end got=%b/%0d want=0/1", err, done_cnt); end
    endtask

    task automatic test_abort_early();
        bit ok;
        clear_mon(); set_cfg(10, 10);
        do_start();
        abort = 1;
        wait_done(ok);
        abort = 0;
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL abe_timeout got=%0d want=1", ok); end
        total++; if ({nwr, log_a[0]} !== {32'd1, 32'h4}) begin bad++; $display("FAIL abe_writes got=%0d/%h want=1/4", nwr, log_a[0]); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL abe_err got=%b want=0", err); end
    endtask

    task automatic test_start_with_abort();
        clear_mon(); set_cfg(10, 10);
        @(negedge aclk); start = 1; abort = 1;
        @(negedge aclk); start = 0; abort = 0;
        repeat (6) @(negedge aclk);
        total++; if ({busy, state, nwr} !== {1'b0, 4'd0, 32'd0}) begin bad++;
            $display("FAIL sab_ignored got=%b/%0h/%0d want=0/0/0", busy, state, nwr); end
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        clear_mon(); set_cfg(2, 5);
        do_start();
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin @(negedge aclk); seen = (state == 4'd5) && m_awvalid; end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL rst_reach_acq got=%b want=1", seen); end
        #1 areset = 1;
        #1;
        total++; if ({m_awvalid, m_wvalid, m_bready, busy, done, err, state} !== 10'b0) begin bad++;
            $display("FAIL rst_async got=%b want=0", {m_awvalid, m_wvalid, m_bready, busy, done, err, state}); end
        repeat (2) @(negedge aclk);
        areset = 0;
        repeat (20) @(negedge aclk);
        total++; if (nwr !== 3) begin bad++; $display("FAIL rst_no_stops got=%0d want=3", nwr); end
        clear_mon(); set_cfg(2, 5);
        do_start(); wait_done(ok);
        total++; if ({ok, nwr} !== {1'b1, 32'd6}) begin bad++; $display("FAIL rst_rerun got=%b/%0d want=1/6", ok, nwr); end
    endtask

`ifdef SESSION_READBACK_EN
    task automatic test_readback();
        bit ok;
        clear_mon(); set_cfg(4, 4); bad_rd = 1;
        do_start(); wait_done(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL rb_timeout got=%0d want=1", ok); end
        total++; if ({err, nwr} !== {1'b1, 32'd4}) begin bad++; $display("FAIL rb_err got=%b/%0d want=1/4", err, nwr); end
        total++; if ({log_a[2], log_a[3]} !== {RHS, 32'h0}) begin bad++; $display("FAIL rb_stops got=%h/%h want=10000/0", log_a[2], log_a[3]); end
    endtask
`endif

    initial begin
        areset = 1; start = 0; abort = 0; ar_cnt = 0; last_wdata = 0;
        clear_mon(); set_cfg(10, 100);
        test_reset();
        test_nominal();
        test_zero_wait();
        test_aw_delay();
        test_slverr();
        test_abort_run();
        test_abort_early();
        test_start_with_abort();
        test_reset_mid();
`ifdef SESSION_READBACK_EN
        test_readback();
`else
        total++; if (ar_cnt !== 0) begin bad++; $display("FAIL no_reads got=%0d want=0", ar_cnt); end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
